// File: rtl/rggen_rtl_pkg.sv
// Shared types for rggen bit-field RTL.
// Provides the set/clear mode and hardware edge-qualification enums, plus the
// register bus data width used by rggen_bit_field_if.
package rggen_rtl_pkg;

    localparam int unsigned RGGEN_DATA_WIDTH = 64;

    typedef enum logic {
        RGGEN_SET_MODE,
        RGGEN_CLEAR_MODE
    } rggen_rwsc_mode;

    typedef enum logic [1:0] {
        RGGEN_HW_LEVEL,
        RGGEN_HW_RISING,
        RGGEN_HW_FALLING,
        RGGEN_HW_BOTH
    } rggen_hw_edge;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register-bus view of a single bit field.
// master: drives write_access/write_data/write_mask, reads read_data/value.
// slave : the bit field; drives read_data and value.
interface rggen_bit_field_if;
    import rggen_rtl_pkg::*;

    logic                        write_access;
    logic [RGGEN_DATA_WIDTH-1:0] write_data;
    logic [RGGEN_DATA_WIDTH-1:0] write_mask;
    logic [RGGEN_DATA_WIDTH-1:0] read_data;
    logic [RGGEN_DATA_WIDTH-1:0] value;

    modport master (
        output write_access,
        output write_data,
        output write_mask,
        input  read_data,
        input  value
    );

    modport slave (
        input  write_access,
        input  write_data,
        input  write_mask,
        output read_data,
        output value
    );

endinterface

// File: rtl/rggen_edge_detector.sv
// Synchronizer plus edge qualification for hardware set/clear requests.
// Ports: clk, rst_n (async active-low), set_or_clear (raw request per bit),
//        evt_c (combinational qualified event per bit).
module rggen_edge_detector
    import rggen_rtl_pkg::*;
#(
    parameter int           WIDTH       = 1,
    parameter int           SYNC_STAGES = 0,
    parameter rggen_hw_edge HW_EDGE     = RGGEN_HW_LEVEL
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] set_or_clear,
    output logic [WIDTH-1:0] evt_c
);

    logic [WIDTH-1:0] hw_s;
    logic [WIDTH-1:0] hw_prev;

    // Optional synchronizer chain; zero stages is a plain pass-through.
    if (SYNC_STAGES == 0) begin : g_no_sync
        assign hw_s = set_or_clear;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= set_or_clear;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign hw_s = sync_q[SYNC_STAGES-1];
    end

    // Previous synchronized sample; resets to 0 so an input held high
    // out of reset looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_prev <= '0;
        end else begin
            hw_prev <= hw_s;
        end
    end

    always_comb begin
        evt_c = hw_s;
        case (HW_EDGE)
            RGGEN_HW_RISING:  evt_c = hw_s & ~hw_prev;
            RGGEN_HW_FALLING: evt_c = ~hw_s & hw_prev;
            RGGEN_HW_BOTH:    evt_c = hw_s ^ hw_prev;
            default:          evt_c = hw_s;
        endcase
    end

endmodule

// File: rtl/rggen_bit_field_w01s_w01c_ex.sv
// Bit field with software write-to-set/clear and hardware clear/set, with
// optional edge qualification, synchronizer and per-bit overrun tracking.
// Ports: clk, rst_n (async active-low), i_set_or_clear (hardware request),
//        bit_field_if (register bus, slave), o_value (field value),
//        o_overrun (per-bit overrun), o_event (pulse on any 0->1 of value).
module rggen_bit_field_w01s_w01c_ex
    import rggen_rtl_pkg::*;
#(
    parameter rggen_rwsc_mode  MODE            = RGGEN_SET_MODE,
    parameter bit              SET_CLEAR_VALUE = 1'b0,
    parameter int              WIDTH           = 1,
    parameter bit [WIDTH-1:0]  INITIAL_VALUE   = '0,
    parameter rggen_hw_edge    HW_EDGE         = RGGEN_HW_LEVEL,
    parameter int              SYNC_STAGES     = 0,
    parameter bit              SET_PRIORITY    = 1'b1,
    parameter bit              OVERRUN_ENABLE  = 1'b0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    i_set_or_clear,
    rggen_bit_field_if.slave    bit_field_if,
    output logic [WIDTH-1:0]    o_value,
    output logic [WIDTH-1:0]    o_overrun,
    output logic                o_event
);

    localparam int unsigned DW = RGGEN_DATA_WIDTH;

    logic [WIDTH-1:0] hw_evt_c;
    logic [WIDTH-1:0] sw_evt_c;
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] next_value_c;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] overrun_q;
    logic             event_q;

    rggen_edge_detector #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .HW_EDGE     (HW_EDGE)
    ) u_edge_detector (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_or_clear (i_set_or_clear),
        .evt_c        (hw_evt_c)
    );

    // Software action: masked write bits matching the trigger polarity.
    always_comb begin
        sw_evt_c = '0;
        if (bit_field_if.write_access) begin
            sw_evt_c = bit_field_if.write_mask[WIDTH-1:0] &
                       (SET_CLEAR_VALUE ? bit_field_if.write_data[WIDTH-1:0]
                                        : ~bit_field_if.write_data[WIDTH-1:0]);
        end
    end

    // Role assignment between software and hardware.
    always_comb begin
        set_c = sw_evt_c;
        clr_c = hw_evt_c;
        if (MODE == RGGEN_CLEAR_MODE) begin
            set_c = hw_evt_c;
            clr_c = sw_evt_c;
        end
    end

    // Per-bit update; a collision resolves to SET_PRIORITY.
    always_comb begin
        next_value_c = SET_PRIORITY ? ((value_q & ~clr_c) | set_c)
                                    : ((value_q | set_c) & ~clr_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= INITIAL_VALUE;
            event_q <= 1'b0;
        end else begin
            value_q <= next_value_c;
            event_q <= |(next_value_c & ~value_q);
        end
    end

    // Overrun: an effective set landing on a bit that is already 1.
    if (OVERRUN_ENABLE) begin : g_overrun
        logic [WIDTH-1:0] eff_set_c;
        logic [WIDTH-1:0] eff_clr_c;

        assign eff_set_c = SET_PRIORITY ? set_c : (set_c & ~clr_c);
        assign eff_clr_c = SET_PRIORITY ? (clr_c & ~set_c) : clr_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                overrun_q <= '0;
            end else begin
                overrun_q <= (overrun_q | (eff_set_c & value_q)) & ~eff_clr_c;
            end
        end
    end else begin : g_no_overrun
        assign overrun_q = '0;
    end

    // Read view: value in the low field, overrun directly above it.
    always_comb begin
        bit_field_if.read_data                   = '0;
        bit_field_if.read_data[WIDTH-1:0]        = value_q;
        bit_field_if.read_data[2*WIDTH-1:WIDTH]  = overrun_q;
    end

    assign bit_field_if.value = DW'(value_q);

    // Bus bits above the field are intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bit_field_if.write_data[DW-1:WIDTH],
                               bit_field_if.write_mask[DW-1:WIDTH]};

    assign o_value   = value_q;
    assign o_overrun = overrun_q;
    assign o_event   = event_q;

endmodule

// File: tb/tb_rggen_bit_field_w01s_w01c_ex.sv
// Directed bench for rggen_bit_field_w01s_w01c_ex across several configurations.
module tb_rggen_bit_field_w01s_w01c_ex;
    import rggen_rtl_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    rggen_bit_field_if if_a();
    rggen_bit_field_if if_b();
    rggen_bit_field_if if_c();
    rggen_bit_field_if if_d();
    rggen_bit_field_if if_e();
    rggen_bit_field_if if_f();

    logic [W-1:0] hw_a, hw_b, hw_cd, hw_ef;
    logic [W-1:0] val_a, val_b, val_c, val_d, val_e, val_f;
    logic [W-1:0] ovr_a, ovr_b, ovr_c, ovr_d, ovr_e, ovr_f;
    logic         evt_a, evt_b, evt_c, evt_d, evt_e, evt_f;

    // a: SET mode, write-1 sets, level hw clear, overrun on
    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_SET_MODE), .SET_CLEAR_VALUE(1'b1), .WIDTH(W), .INITIAL_VALUE(4'h0),
        .HW_EDGE(RGGEN_HW_LEVEL), .SYNC_STAGES(0), .SET_PRIORITY(1'b1), .OVERRUN_ENABLE(1'b1)
    ) u_a (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_a), .bit_field_if(if_a.slave),
           .o_value(val_a), .o_overrun(ovr_a), .o_event(evt_a));

    // b: rising-edge hw clear through a 2-flop synchronizer, resets to all ones
    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_SET_MODE), .SET_CLEAR_VALUE(1'b1), .WIDTH(W), .INITIAL_VALUE(4'hF),
        .HW_EDGE(RGGEN_HW_RISING), .SYNC_STAGES(2), .SET_PRIORITY(1'b1), .OVERRUN_ENABLE(1'b0)
    ) u_b (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_b), .bit_field_if(if_b.slave),
           .o_value(val_b), .o_overrun(ovr_b), .o_event(evt_b));

    // c/d: write-0 sets, set priority vs clear priority
    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_SET_MODE), .SET_CLEAR_VALUE(1'b0), .WIDTH(W), .INITIAL_VALUE(4'h0),
        .HW_EDGE(RGGEN_HW_LEVEL), .SYNC_STAGES(0), .SET_PRIORITY(1'b1), .OVERRUN_ENABLE(1'b0)
    ) u_c (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_cd), .bit_field_if(if_c.slave),
           .o_value(val_c), .o_overrun(ovr_c), .o_event(evt_c));

    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_SET_MODE), .SET_CLEAR_VALUE(1'b0), .WIDTH(W), .INITIAL_VALUE(4'h0),
        .HW_EDGE(RGGEN_HW_LEVEL), .SYNC_STAGES(0), .SET_PRIORITY(1'b0), .OVERRUN_ENABLE(1'b0)
    ) u_d (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_cd), .bit_field_if(if_d.slave),
           .o_value(val_d), .o_overrun(ovr_d), .o_event(evt_d));

    // e/f: CLEAR mode (hw sets, sw clears); both-edge vs level
    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_CLEAR_MODE), .SET_CLEAR_VALUE(1'b1), .WIDTH(W), .INITIAL_VALUE(4'h0),
        .HW_EDGE(RGGEN_HW_BOTH), .SYNC_STAGES(0), .SET_PRIORITY(1'b1), .OVERRUN_ENABLE(1'b0)
    ) u_e (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_ef), .bit_field_if(if_e.slave),
           .o_value(val_e), .o_overrun(ovr_e), .o_event(evt_e));

    rggen_bit_field_w01s_w01c_ex #(
        .MODE(RGGEN_CLEAR_MODE), .SET_CLEAR_VALUE(1'b1), .WIDTH(W), .INITIAL_VALUE(4'h0),
        .HW_EDGE(RGGEN_HW_LEVEL), .SYNC_STAGES(0), .SET_PRIORITY(1'b1), .OVERRUN_ENABLE(1'b0)
    ) u_f (.clk(clk), .rst_n(rst_n), .i_set_or_clear(hw_ef), .bit_field_if(if_f.slave),
           .o_value(val_f), .o_overrun(ovr_f), .o_event(evt_f));

    typedef struct {
        logic         wa;
        logic [W-1:0] wd;
        logic [W-1:0] wm;
        logic [W-1:0] hw;
        logic [W-1:0] value;
        logic [W-1:0] ovr;
        logic         evt;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic wa, input logic [W-1:0] wd, input logic [W-1:0] wm,
                           input logic [W-1:0] hw);
        if_a.write_access = wa;
        if_a.write_data   = 64'(wd);
        if_a.write_mask   = 64'(wm);
        hw_a              = hw;
    endtask

    task automatic drive_b(input logic wa, input logic [W-1:0] wd, input logic [W-1:0] wm);
        if_b.write_access = wa;
        if_b.write_data   = 64'(wd);
        if_b.write_mask   = 64'(wm);
    endtask

    task automatic drive_cd(input logic wa, input logic [W-1:0] wd, input logic [W-1:0] wm,
                            input logic [W-1:0] hw);
        if_c.write_access = wa;
        if_c.write_data   = 64'(wd);
        if_c.write_mask   = 64'(wm);
        if_d.write_access = wa;
        if_d.write_data   = 64'(wd);
        if_d.write_mask   = 64'(wm);
        hw_cd             = hw;
    endtask

    task automatic drive_ef(input logic wa, input logic [W-1:0] wd, input logic [W-1:0] wm,
                            input logic [W-1:0] hw);
        if_e.write_access = wa;
        if_e.write_data   = 64'(wd);
        if_e.write_mask   = 64'(wm);
        if_f.write_access = wa;
        if_f.write_data   = 64'(wd);
        if_f.write_mask   = 64'(wm);
        hw_ef             = hw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] exp4;
        logic         in_cur;
        logic         in_prev;
        int           pulses;

        //               wa    wd       wm       hw       value    ovr      evt
        vecs[0]  = '{1'b1, 4'b0101, 4'hF,    4'h0,    4'b0101, 4'b0000, 1'b1};
        vecs[1]  = '{1'b0, 4'b0000, 4'h0,    4'h0,    4'b0101, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'hF,    4'h0,    4'b0101, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 4'b0100, 4'hF,    4'h0,    4'b0101, 4'b0100, 1'b0};
        vecs[4]  = '{1'b1, 4'b1010, 4'b0011, 4'h0,    4'b0111, 4'b0100, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 4'h0,    4'b0100, 4'b0011, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 4'b1000, 4'hF,    4'b1000, 4'b1011, 4'b0000, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 4'h0,    4'b0001, 4'b1010, 4'b0000, 1'b0};
        vecs[8]  = '{1'b1, 4'b0001, 4'hF,    4'b0001, 4'b1011, 4'b0000, 1'b1};
        vecs[9]  = '{1'b1, 4'b1000, 4'hF,    4'h0,    4'b1011, 4'b1000, 1'b0};
        vecs[10] = '{1'b1, 4'b1001, 4'hF,    4'h0,    4'b1011, 4'b1001, 1'b0};
        vecs[11] = '{1'b1, 4'b0010, 4'hF,    4'b0010, 4'b1011, 4'b1011, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'h0,    4'b1111, 4'b0000, 4'b0000, 1'b0};
        vecs[13] = '{1'b0, 4'b0000, 4'h0,    4'h0,    4'b0000, 4'b0000, 1'b0};
        vecs[14] = '{1'b1, 4'b0110, 4'hF,    4'h0,    4'b0110, 4'b0000, 1'b1};
        vecs[15] = '{1'b1, 4'b0110, 4'hF,    4'h0,    4'b0110, 4'b0110, 1'b0};

        rst_n = 1'b0;
        drive_a(1'b0, 4'h0, 4'h0, 4'h0);
        drive_b(1'b0, 4'h0, 4'h0);
        hw_b = 4'h0;
        drive_cd(1'b0, 4'h0, 4'h0, 4'h0);
        drive_ef(1'b0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst.a.value",  64'(val_a), 64'h0);
        check("rst.a.ovr",    64'(ovr_a), 64'h0);
        check("rst.a.event",  64'(evt_a), 64'h0);
        check("rst.a.rdata",  if_a.read_data, 64'h0);
        check("rst.b.value",  64'(val_b), 64'hF);
        check("rst.b.rdata",  if_b.read_data, 64'hF);

        @(negedge clk);
        rst_n = 1'b1;

        // Table: software set, hw level clear, collisions, overrun
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_a(vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].hw);
            step();
            check($sformatf("vec%0d.value", i), 64'(val_a), 64'(vecs[i].value));
            check($sformatf("vec%0d.ovr", i),   64'(ovr_a), 64'(vecs[i].ovr));
            check($sformatf("vec%0d.event", i), 64'(evt_a), 64'(vecs[i].evt));
            check($sformatf("vec%0d.rdata", i), if_a.read_data, 64'({vecs[i].ovr, vecs[i].value}));
            check($sformatf("vec%0d.ifval", i), if_a.value, 64'(vecs[i].value));
        end

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        drive_a(1'b1, 4'b1001, 4'hF, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.a.value", 64'(val_a), 64'h0);
        check("arst.a.ovr",   64'(ovr_a), 64'h0);
        check("arst.a.event", 64'(evt_a), 64'h0);
        check("arst.b.value", 64'(val_b), 64'hF);
        step();
        check("arst.hold.a.value", 64'(val_a), 64'h0);
        check("arst.hold.a.ovr",   64'(ovr_a), 64'h0);
        @(negedge clk);
        drive_a(1'b0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        // Rising edge through two sync stages: clear lands on the third clock
        @(negedge clk);
        hw_b = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp4 = (k >= 3) ? 4'b1101 : 4'b1111;
            check($sformatf("sync.clk%0d.value", k), 64'(val_b), 64'(exp4));
            check($sformatf("sync.clk%0d.event", k), 64'(evt_b), 64'h0);
        end
        check("sync.ovr", 64'(ovr_b), 64'h0);
        check("sync.rdata", if_b.read_data, 64'hD);
        @(negedge clk);
        drive_b(1'b1, 4'b0010, 4'hF);
        step();
        check("sync.swset.value", 64'(val_b), 64'hF);
        check("sync.swset.event", 64'(evt_b), 64'h1);
        @(negedge clk);
        drive_b(1'b0, 4'h0, 4'h0);
        repeat (4) step();
        check("sync.held.value", 64'(val_b), 64'hF);
        @(negedge clk);
        hw_b = 4'h0;
        repeat (4) step();
        check("sync.fall.value", 64'(val_b), 64'hF);

        // Same-cycle write-0 set and hw clear on bit0
        @(negedge clk);
        drive_cd(1'b1, 4'h0, 4'hF, 4'h1);
        step();
        check("prio.c.value", 64'(val_c), 64'hF);
        check("prio.d.value", 64'(val_d), 64'hE);
        check("prio.c.event", 64'(evt_c), 64'h1);
        check("prio.d.event", 64'(evt_d), 64'h1);
        @(negedge clk);
        drive_cd(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        check("prio.hold.c", 64'(val_c), 64'hF);
        check("prio.hold.d", 64'(val_d), 64'hE);
        check("prio.hold.c.event", 64'(evt_c), 64'h0);
        @(negedge clk);
        drive_cd(1'b1, 4'hF, 4'hF, 4'h0);
        step();
        check("prio.w1noop.c", 64'(val_c), 64'hF);
        check("prio.w1noop.d", 64'(val_d), 64'hE);
        @(negedge clk);
        drive_cd(1'b0, 4'h0, 4'h0, 4'h1);
        step();
        check("prio.hwclr.c", 64'(val_c), 64'hE);
        check("prio.hwclr.d", 64'(val_d), 64'hE);
        @(negedge clk);
        drive_cd(1'b1, 4'b1110, 4'b0001, 4'h0);
        step();
        check("prio.mask.c", 64'(val_c), 64'hF);
        check("prio.mask.d", 64'(val_d), 64'hF);
        check("prio.mask.d.event", 64'(evt_d), 64'h1);
        check("prio.ovr", 64'({ovr_c, ovr_d}), 64'h0);

        // Both-edge vs level hardware set, software clearing every cycle
        @(negedge clk);
        drive_ef(1'b1, 4'hF, 4'hF, 4'h0);
        step();
        check("edge.init.e", 64'(val_e), 64'h0);
        check("edge.init.f", 64'(val_f), 64'h0);
        in_prev = 1'b0;
        pulses  = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            in_cur = ((n / 3) % 2) == 1;
            hw_ef  = {3'b000, in_cur};
            step();
            exp4 = {3'b000, in_cur ^ in_prev};
            check($sformatf("edge.n%0d.e.value", n), 64'(val_e), 64'(exp4));
            check($sformatf("edge.n%0d.e.event", n), 64'(evt_e), 64'(in_cur ^ in_prev));
            check($sformatf("edge.n%0d.f.value", n), 64'(val_f), 64'({3'b000, in_cur}));
            check($sformatf("edge.n%0d.f.event", n), 64'(evt_f), 64'(in_cur & ~in_prev));
            if (val_e[0]) pulses++;
            in_prev = in_cur;
        end
        check("edge.pulses", 64'(pulses), 64'd4);
        check("edge.ovr", 64'({ovr_e, ovr_f}), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
